primogen_seek: RTL and testbench

//  Parametrised prime generator: on each go, either advances to the next prime after the

---
 rtl/primogen_seek.sv | 221 ++++++++++++++++++++++
 tb/tb_primogen_seek.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/primogen_seek.sv
// primogen_seek: prime generator with NEXT / SEEK requests.
//   NEXT finds the next prime after res; SEEK finds the smallest prime >= start.
//   Odd candidates are trial-divided by a RAM table of earlier primes (3,5,7,...).
//   Once the table is used up, the search continues with odd divisors.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   go, mode, start request (mode 0 = NEXT, 1 = SEEK), sampled while ready=1
//   ready           idle; res/error valid and stable
//   error           last request failed (no prime fits in WIDTH, or divider error)
//   res             current prime (1 after reset)

// primogen_divrem: restoring divider, W cycles per division; only the remainder is kept.
module primogen_divrem #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         ready,
    output logic         error,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  n_sh, d_q, r_q, r_sub;
    logic [W:0]    r_sh;

    assign r_sh  = {r_q, n_sh[W-1]};
    // r_sh < 2*d_q, so the difference always fits in W bits.
    assign r_sub = r_sh[W-1:0] - d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            error <= 1'b0;
            cnt   <= '0;
            n_sh  <= '0;
            d_q   <= '0;
            r_q   <= '0;
        end else if (!busy) begin
            if (go) begin
                error <= (den == '0);
                busy  <= (den != '0);
                n_sh  <= num;
                d_q   <= den;
                r_q   <= '0;
                cnt   <= CNT_INIT;
            end
        end else begin
            n_sh <= {n_sh[W-2:0], 1'b0};
            r_q  <= (r_sh >= {1'b0, d_q}) ? r_sub : r_sh[W-1:0];
            cnt  <= cnt - 1'b1;
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

    assign ready = ~busy;
    assign rem   = r_q;
endmodule

module primogen_seek #(
    parameter int WIDTH_LOG  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      go,
    input  logic                      mode,
    input  logic [(1<<WIDTH_LOG)-1:0] start,
    output logic                      ready,
    output logic                      error,
    output logic [(1<<WIDTH_LOG)-1:0] res
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int SQW   = 2 * WIDTH;
    localparam logic [WIDTH:0]        C2 = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]        C3 = (WIDTH+1)'(3);
    localparam logic [WIDTH:0]        C9 = (WIDTH+1)'(9);
    localparam logic [ADDR_WIDTH-1:0] TBL_FULL = '1;

    typedef enum logic [2:0] {
        IDLE, ERR, CAND, TBL_RD, TBL_DIV, SLOW_DIV, SLOW_NEXT, STORE
    } state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_SKIP, PH_WAIT} phase_t;
    typedef enum logic {NEXT = 1'b0, SEEK = 1'b1} mode_t;

    state_t              state, state_n;
    phase_t              ph, ph_n;
    mode_t               mode_q, mode_n;
    logic [WIDTH-1:0]    res_n, tmax, tmax_n, d, d_n, rd_data;
    logic                err_n, found, append_ok;
    logic [WIDTH:0]      c, c_n, cand;
    logic [ADDR_WIDTH-1:0] idx, idx_n, naddrs, naddrs_n;
    logic [SQW-1:0]      dsq, dsq_n, c_ext, p_ext, psq, p_next_sq, d_next_sq;
    logic                dv_go, dv_ready, dv_error;
    logic [WIDTH-1:0]    dv_den, dv_rem;
    logic [WIDTH-1:0]    mem [0:(1<<ADDR_WIDTH)-1];

    // NOTE: the prime table is RAM without reset; naddrs alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (state == STORE) mem[naddrs] <= c[WIDTH-1:0];
        rd_data <= mem[idx];
    end

    primogen_divrem #(.W(WIDTH)) u_divrem (
        .clk(clk), .rst_n(rst_n), .go(dv_go), .num(c[WIDTH-1:0]), .den(dv_den),
        .ready(dv_ready), .error(dv_error), .rem(dv_rem)
    );

    assign c_ext     = {{(WIDTH-1){1'b0}}, c};
    assign p_ext     = {{WIDTH{1'b0}}, rd_data};
    assign psq       = p_ext * p_ext;
    // (x+2)^2 = x^2 + 4x + 4, so the slow path never needs a multiplier.
    assign p_next_sq = psq + {{(WIDTH-2){1'b0}}, rd_data, 2'b00} + SQW'(4);
    assign d_next_sq = dsq + {{(WIDTH-2){1'b0}}, d, 2'b00} + SQW'(4);
    assign ready     = (state == IDLE) || (state == ERR);

    // Only NEXT results extend the table: a SEEK result may skip primes and would
    // leave a hole in the ascending divisor list.
    assign append_ok = (mode_q == NEXT) && (c != C2) && (naddrs != TBL_FULL) &&
                       ((res == tmax) || ((tmax == '0) && (res <= WIDTH'(2))));

    always_comb begin
        cand = {1'b0, res} + C2;
        if (mode == SEEK) begin
            if (start <= WIDTH'(2))  cand = C2;
            else if (start[0])       cand = {1'b0, start};
            else                     cand = {1'b0, start} + (WIDTH+1)'(1);
        end else if (res == WIDTH'(1)) begin
            cand = C2;
        end else if (res == WIDTH'(2)) begin
            cand = C3;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_n = state;  ph_n = ph;   mode_n = mode_q;  c_n = c;
        res_n = res;      err_n = error;  idx_n = idx;   naddrs_n = naddrs;
        tmax_n = tmax;    d_n = d;     dsq_n = dsq;
        dv_go = 1'b0;     dv_den = d;  found = 1'b0;
        case (state)
            IDLE, ERR: if (go) begin
                mode_n  = mode_t'(mode);
                c_n     = cand;
                state_n = CAND;
            end
            CAND: begin
                if (c[WIDTH]) begin
                    err_n = 1'b1; state_n = ERR;
                end else if (c <= C3) begin
                    found = 1'b1;
                end else if (naddrs == '0) begin
                    d_n = WIDTH'(3); dsq_n = SQW'(9);
                    if (c < C9) found = 1'b1;
                    else begin ph_n = PH_ISSUE; state_n = SLOW_DIV; end
                end else begin
                    idx_n = '0; state_n = TBL_RD;
                end
            end
            TBL_RD: begin ph_n = PH_ISSUE; state_n = TBL_DIV; end
            TBL_DIV, SLOW_DIV: begin
                dv_den = (state == TBL_DIV) ? rd_data : d;
                case (ph)
                    PH_ISSUE:
                        if ((state == TBL_DIV) && (psq > c_ext)) found = 1'b1;
                        else begin dv_go = 1'b1; ph_n = PH_SKIP; end
                    // The divider's ready is not trusted in the cycle right after go.
                    PH_SKIP: ph_n = PH_WAIT;
                    default: if (dv_ready) begin
                        if (dv_error) begin
                            err_n = 1'b1; state_n = ERR;
                        end else if (dv_rem == '0) begin
                            c_n = c + C2; state_n = CAND;
                        end else if (state == SLOW_DIV) begin
                            state_n = SLOW_NEXT;
                        end else if (idx + 1'b1 < naddrs) begin
                            idx_n = idx + 1'b1; state_n = TBL_RD;
                        end else begin
                            d_n = rd_data + WIDTH'(2); dsq_n = p_next_sq;
                            if (p_next_sq > c_ext) found = 1'b1;
                            else begin ph_n = PH_ISSUE; state_n = SLOW_DIV; end
                        end
                    end
                endcase
            end
            SLOW_NEXT: begin
                d_n = d + WIDTH'(2); dsq_n = d_next_sq;
                if (d_next_sq > c_ext) found = 1'b1;
                else begin ph_n = PH_ISSUE; state_n = SLOW_DIV; end
            end
            STORE: begin
                res_n = c[WIDTH-1:0]; tmax_n = c[WIDTH-1:0]; err_n = 1'b0;
                naddrs_n = naddrs + 1'b1; state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (found) begin
            if (append_ok) state_n = STORE;
            else begin res_n = c[WIDTH-1:0]; err_n = 1'b0; state_n = IDLE; end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;  ph <= PH_ISSUE;  mode_q <= NEXT;  c <= '0;
            res <= WIDTH'(1);  error <= 1'b0;  idx <= '0;  naddrs <= '0;
            tmax <= '0;  d <= '0;  dsq <= '0;
        end else begin
            state <= state_n;  ph <= ph_n;  mode_q <= mode_n;  c <= c_n;
            res <= res_n;  error <= err_n;  idx <= idx_n;  naddrs <= naddrs_n;
            tmax <= tmax_n;  d <= d_n;  dsq <= dsq_n;
        end
    end
endmodule

// File: tb/tb_primogen_seek.sv
// Self-checking bench for primogen_seek (WIDTH_LOG=4, 7-entry prime table).
module tb_primogen_seek;
    localparam int     W       = 16;
    localparam longint MAXV    = 65535;
    localparam int     TBL_CAP = 7;

    logic         clk = 1'b0, rst_n = 1'b0, go = 1'b0, mode = 1'b0;
    logic [W-1:0] start = '0;
    logic         ready, error;
    logic [W-1:0] res;

    primogen_seek #(.WIDTH_LOG(4), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .start(start),
        .ready(ready), .error(error), .res(res)
    );

    always #5 clk = ~clk;

    int     n_checks = 0, n_fail = 0;
    longint m_res = 1, m_tmax = 0;
    int     m_naddrs = 0;
    bit     m_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime(input longint n);
        if (n < 2) return 0;
        for (longint k = 2; k * k <= n; k++) if (n % k == 0) return 0;
        return 1;
    endfunction

    function automatic longint prime_ge(input longint n);
        longint k = n;
        while (!is_prime(k)) k++;
        return k;
    endfunction

    task automatic model_reset;
        m_res = 1; m_err = 0; m_naddrs = 0; m_tmax = 0;
    endtask

    // Reference: result is the smallest prime above res (NEXT) or >= start (SEEK).
    task automatic model_go(input bit m, input longint s);
        longint q;
        q = m ? prime_ge(s) : prime_ge(m_res + 1);
        if (q > MAXV) begin
            m_err = 1;
        end else begin
            if (!m && q != 2 && m_naddrs < TBL_CAP &&
                (m_res == m_tmax || (m_tmax == 0 && m_res <= 2))) begin
                m_naddrs++;
                m_tmax = q;
            end
            m_res = q;
            m_err = 0;
        end
    endtask

    // Compare DUT against the model on every idle cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && ready === 1'b1) begin
            check("cmp_res", res, m_res);
            check("cmp_err", error, m_err);
            check("cmp_naddrs", dut.naddrs, m_naddrs);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ready === 1'b1) return;
        end
        check("ready_timeout", ready, 1);
    endtask

    task automatic launch(input bit m, input logic [W-1:0] s);
        wait_ready();
        go = 1'b1; mode = m; start = s;
        @(posedge clk); #1;
        go = 1'b0;
        model_go(m, s);
    endtask

    task automatic req(input bit m, input logic [W-1:0] s);
        launch(m, s);
        wait_ready();
    endtask

    task automatic req_noisy(input bit m, input logic [W-1:0] s);
        launch(m, s);
        repeat (4) begin
            @(negedge clk);
            if (ready === 1'b0) begin
                go = 1'b1; mode = ~m; start = W'($urandom);
                @(posedge clk); #1;
                go = 1'b0;
            end
        end
        wait_ready();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int t1_exp [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
    int t2_in  [5]  = '{0, 2, 90, 97, 200};
    int t2_exp [5]  = '{2, 2, 97, 97, 211};

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_res", res, 1);
        check("rst_err", error, 0);

        for (int i = 0; i < 10; i++) begin
            req(1'b0, '0);
            check("t1_next", res, t1_exp[i]);
            check("t1_err", error, 0);
        end

        for (int i = 0; i < 5; i++) begin
            req(1'b1, W'(t2_in[i]));
            check("t2_seek", res, t2_exp[i]);
        end

        do_reset();
        for (int i = 0; i < 60; i++) req(1'b0, '0);
        check("t3_prime60", res, 281);
        check("t3_naddrs", dut.naddrs, 7);

        req(1'b1, W'(65522));
        check("t4_ovf_err", error, 1);
        check("t4_ovf_res", res, 281);
        req(1'b1, W'(65520));
        check("t4_seek_res", res, 65521);
        check("t4_seek_err", error, 0);
        req(1'b0, '0);
        check("t4_next_err", error, 1);
        check("t4_next_res", res, 65521);

        do_reset();
        for (int i = 0; i < 5; i++) req(1'b0, '0);
        check("t5_res11", res, 11);
        check("t5_naddrs4", dut.naddrs, 4);
        req(1'b1, W'(100));
        check("t5_seek101", res, 101);
        check("t5_naddrs_seek", dut.naddrs, 4);
        req(1'b0, '0);
        check("t5_next103", res, 103);
        check("t5_naddrs_gap", dut.naddrs, 4);
        req(1'b1, W'(11));
        check("t5_seek11", res, 11);
        req(1'b0, '0);
        check("t5_next13", res, 13);
        check("t5_naddrs5", dut.naddrs, 5);

        req_noisy(1'b0, '0);
        check("t6_noisy", res, 17);
        launch(1'b1, W'(65520));
        repeat (40) @(negedge clk);
        check("t6_busy", ready, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_ready", ready, 1);
        check("t6_rst_res", res, 1);
        check("t6_rst_err", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b0, '0);
        check("t6_after_rst", res, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
